// File: rtl/muxn_arb_if.sv
// muxn_arb_if: handshake bundle between N producer channels, the arbiter and one consumer.
interface muxn_arb_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = 2
);
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_ch;
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/muxn_arb.sv
// muxn_arb: registered N:1 mux with valid/ready handshake, manual select or round-robin grant.
module muxn_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = 2
) (
    input logic      clk,
    input logic      rst_n,
    muxn_arb_if.slave bus
);
    localparam int SPAN = 1 << SELW;
    logic [SELW-1:0]  ptr_q, ptr_d, out_ch_q, out_ch_d, rr_grant, grant, idx;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SPAN-1:0]  valid_ext;
    logic             grant_ok, can_load, xfer;
    always_comb begin
        valid_ext = '0;
        valid_ext[N-1:0] = bus.in_valid;
        rr_grant = ptr_q;
        idx = ptr_q;
        // Walk from ptr itself back to ptr+1 so the closest valid channel after ptr wins.
        for (int k = N; k >= 1; k--) begin
            idx = SELW'((int'(ptr_q) + k) % N);
            if (valid_ext[idx]) rr_grant = idx;
        end
        grant = bus.mode ? rr_grant : bus.sel;
        // Unused upper slots of valid_ext are zero, so sel >= N never grants.
        grant_ok = bus.mode ? |bus.in_valid : valid_ext[bus.sel];
        can_load = !out_valid_q | bus.out_ready;
        xfer = rst_n & can_load & grant_ok;
        bus.in_ready = xfer ? N'(1) << grant : '0;
        out_data_d = xfer ? bus.in_data[grant*WIDTH +: WIDTH] : out_data_q;
        out_ch_d = xfer ? grant : out_ch_q;
        out_valid_d = xfer | (out_valid_q & !bus.out_ready);
        ptr_d = (xfer & bus.mode) ? grant : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_muxn_arb.sv
// tb_muxn_arb: scoreboard bench for a 4-channel arbiter plus directed checks on a 3-channel build.
module tb_muxn_arb;
    logic clk = 1'b0;
    logic rst_n;
    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 3;
    bit m_valid = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    muxn_arb_if #(.N(4), .WIDTH(8), .SELW(2)) bus ();
    muxn_arb_if #(.N(3), .WIDTH(8), .SELW(2)) b3 ();

    muxn_arb #(.N(4), .WIDTH(8), .SELW(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    muxn_arb #(.N(3), .WIDTH(8), .SELW(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the 4-channel instance, evaluated mid-cycle before the edge.
    task automatic model_step();
        int g;
        bit ok;
        logic [3:0] er;
        g = 0;
        ok = 1'b0;
        if (bus.mode) begin
            for (int j = 1; j <= 4; j++) begin
                int c;
                c = (m_ptr + j) % 4;
                if (!ok && bus.in_valid[c]) begin
                    g = c;
                    ok = 1'b1;
                end
            end
        end else begin
            g = int'(bus.sel);
            ok = bus.in_valid[g];
        end
        er = (rst_n && ok && (!m_valid || bus.out_ready)) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid && exp_q.size() > 0) chk("out_word", 32'({bus.out_ch, bus.out_data}), 32'(exp_q[0]));
        if (!rst_n) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr = 3;
        end else begin
            if (m_valid && bus.out_ready) begin
                void'(exp_q.pop_front());
                m_valid = 1'b0;
            end
            if (er != 4'b0000) begin
                exp_q.push_back({2'(g), bus.in_data[g*8 +: 8]});
                m_valid = 1'b1;
                if (bus.mode) m_ptr = g;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq_sparse [3];
        logic [1:0] seq_n3 [4];
        seq_sparse = '{2'd3, 2'd0, 2'd3};
        seq_n3 = '{2'd0, 2'd1, 2'd2, 2'd0};
        rst_n = 1'b0;
        bus.mode = 1'b1;
        bus.sel = 2'd0;
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        b3.mode = 1'b0;
        b3.sel = 2'd0;
        b3.in_data = {8'h32, 8'h31, 8'h30};
        b3.in_valid = 3'b000;
        b3.out_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_ch", 32'(bus.out_ch), 32'(i % 4));
            chk("rr_data", 32'(bus.out_data), 32'(8'h10 + i % 4));
            chk("rr_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        bus.in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        cyc();
        chk("man_data", 32'(bus.out_data), 32'hA5);
        chk("man_ch", 32'(bus.out_ch), 32'h2);
        bus.in_valid = 4'b1011;
        cyc();
        chk("man_drain_valid", 32'(bus.out_valid), 32'h0);
        chk("man_drain_hold", 32'(bus.out_data), 32'hA5);
        bus.mode = 1'b1;
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid = 4'b0010;
        cyc();
        chk("sparse_ptr1", 32'(bus.out_ch), 32'h1);
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sparse_ch", 32'(bus.out_ch), 32'(seq_sparse[i]));
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_ch", 32'(bus.out_ch), 32'h3);
            chk("stall_data", 32'(bus.out_data), 32'h13);
            chk("stall_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("reload_valid", 32'(bus.out_valid), 32'h1);
        chk("reload_ch", 32'(bus.out_ch), 32'h0);
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        rst_n = 1'b1;
        bus.in_valid = 4'b0000;
        b3.sel = 2'd3;
        b3.in_valid = 3'b111;
        repeat (2) begin
            cyc();
            chk("n3_sel3_ready", 32'(b3.in_ready), 32'h0);
            chk("n3_sel3_valid", 32'(b3.out_valid), 32'h0);
        end
        b3.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("n3_wrap_ch", 32'(b3.out_ch), 32'(seq_n3[i]));
            chk("n3_wrap_data", 32'(b3.out_data), 32'(8'h30 + seq_n3[i]));
        end
        b3.in_valid = 3'b000;
        for (int i = 0; i < 300; i++) begin
            bus.mode = 1'($urandom_range(0, 1));
            bus.sel = 2'($urandom_range(0, 3));
            bus.in_valid = 4'($urandom);
            bus.in_data = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/muxn_arb.md
Name: muxn_arb

Overview:
Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output. It replaces fixed 2:1 combinational muxes wherever a channel select must cross a pipeline stage. There are two modes: manual select (external sel) and round-robin arbitration among valid inputs. It sits between N producer channels and a single consumer, and adds one register stage.

Parameters:
N, 4, number of input channels (2..16)
WIDTH, 8, data width per channel in bits
SELW, 2, select/channel-index width; must equal ceil(log2(N))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = manual select, 1 = round-robin arbitration
sel  input  SELW  channel index used in manual mode
in_data  input  N*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready, one-hot or zero
out_data  output  WIDTH  registered output data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word
out_ch  output  SELW  channel index of the word in out_data

Behaviour:
- Clocking and reset: single clock domain, all state updates on the rising edge of clk. Reset is synchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr pointer ptr=N-1, so channel 0 has first round-robin priority.
- Reset mid-operation: any held word is dropped, no handshake completes in that cycle, and in_ready=0 while rst_n=0.
- Load condition: can_load = !out_valid | out_ready.
- Grant is combinational from the current inputs.
  - mode=0: grant=sel, grant_ok = (sel<N) & in_valid[sel]. If sel>=N, nothing is granted and no channel sees ready.
  - mode=1: grant is the first i with in_valid[i]=1, searching ptr+1, ptr+2, … modulo N and ending with ptr itself. grant_ok = |in_valid.
- in_ready[i] = can_load & grant_ok & (i==grant). At most one bit is set, and it never depends on in_valid[i] of a different channel in manual mode.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge: out_data<=in_data[grant], out_ch<=grant, out_valid<=1.
- ptr<=grant on a transfer only when mode=1. ptr holds in manual mode and when no transfer occurs.
- Drain without reload (out_valid & out_ready & no transfer): out_valid<=0. out_data and out_ch hold their last values.
- Stall (out_valid & !out_ready): out_data, out_ch and out_valid hold, and all in_ready=0.
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle when out_ready is held high (simultaneous drain and load in the same cycle).
- mode or sel may change any cycle and take effect on that cycle's grant. A word already in the output register is unaffected.
- Round-robin fairness: with all N inputs continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0. No channel waits more than N-1 transfers.
- Producer obligation: in_data and in_valid must hold while in_valid=1 and in_ready=0. The block does not check this.
- N not a power of two: pointer arithmetic wraps at N, not at 2^SELW.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release -> first rr grant is channel 0.
- Manual select (N=4, WIDTH=8): mode=0, sel=2, in_data ch2=8'hA5, all valid, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_ch=2. Then set sel=2 with in_valid[2]=0 -> in_ready=0 and out_valid falls after the drain.
- Round-robin: mode=1, all four valid, ch i data=8'h10+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with matching out_data, back-to-back with no bubbles.
- Sparse round-robin: after ptr=1, only in_valid[0] and in_valid[3] high -> grants 3 then 0 then 3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data and out_ch stable, in_ready=0. Raise out_ready with a pending input -> drain and reload occur in the same cycle, out_valid stays 1.
- Edge cases: N=3 build with mode=0, sel=3 -> no grant, out_valid=0. In rr mode, ptr=2 wraps to a channel-0 grant. Assert rst_n=0 while out_valid=1 -> out_valid=0 on the next edge.
